// File: rtl/matrix_add_pipe_if.sv
// Control handshake plus A/B read ports and C write port of the matrix adder.
// The host (master) drives start and read data; the adder core (slave) drives the rest.
interface matrix_add_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);

    logic              ap_start;
    logic              ap_done;
    logic              ap_ready;
    logic              ap_idle;

    logic [ADDR_W-1:0] a_address0;
    logic              a_ce0;
    logic [DATA_W-1:0] a_q0;

    logic [ADDR_W-1:0] b_address0;
    logic              b_ce0;
    logic [DATA_W-1:0] b_q0;

    logic [ADDR_W-1:0] c_address0;
    logic              c_ce0;
    logic              c_we0;
    logic [DATA_W-1:0] c_d0;

    modport master (
        output ap_start, a_q0, b_q0,
        input  ap_done, ap_ready, ap_idle,
        input  a_address0, a_ce0, b_address0, b_ce0,
        input  c_address0, c_ce0, c_we0, c_d0
    );

    modport slave (
        input  ap_start, a_q0, b_q0,
        output ap_done, ap_ready, ap_idle,
        output a_address0, a_ce0, b_address0, b_ce0,
        output c_address0, c_ce0, c_we0, c_d0
    );

endinterface

// File: rtl/matrix_add_pipe.sv
// Element-wise C = A + B over a ROWS x COLS matrix, streamed one index per cycle
// through a read / add / write pipeline against 1-cycle-latency memories.
module matrix_add_pipe #(
    parameter int unsigned ROWS   = 3,
    parameter int unsigned COLS   = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = $clog2((ROWS * COLS) > 1 ? (ROWS * COLS) : 2)
) (
    input logic               ap_clk,
    input logic               ap_rst,
    matrix_add_pipe_if.slave  bus
);

    localparam int unsigned N     = ROWS * COLS;
    // Issue counter must be able to hold N itself so it can saturate there.
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StRun  = 3'b010,
        StDone = 3'b100
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic               iter0;
    logic               iter1_q;
    logic               iter2_q;
    logic [ADDR_W-1:0]  addr1_q;
    logic [ADDR_W-1:0]  addr2_q;
    logic [DATA_W-1:0]  sum_q;
    logic               last_drain;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        iter0      = (state_q == StRun) && (k_q < CNT_W'(N));
        // Pipeline is empty behind the final write once issue has stopped.
        last_drain = (state_q == StRun) && !iter0 && !iter1_q && iter2_q;

        unique case (state_q)
            StIdle: begin
                if (bus.ap_start) begin
                    state_d = StRun;
                    k_d     = '0;
                end
            end
            StRun: begin
                if (iter0) begin
                    k_d = k_q + CNT_W'(1);
                end
                if (last_drain) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            iter1_q <= 1'b0;
            iter2_q <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            iter1_q <= iter0;
            iter2_q <= iter1_q;
            addr1_q <= ADDR_W'(k_q);
            if (iter1_q) begin
                addr2_q <= addr1_q;
                sum_q   <= bus.a_q0 + bus.b_q0;
            end
        end
    end

    always_comb begin
        bus.ap_idle    = (state_q == StIdle);
        bus.ap_done    = (state_q == StDone);
        bus.ap_ready   = (state_q == StDone);

        bus.a_ce0      = iter0;
        bus.b_ce0      = iter0;
        bus.a_address0 = ADDR_W'(k_q);
        bus.b_address0 = ADDR_W'(k_q);

        bus.c_ce0      = iter2_q;
        bus.c_we0      = iter2_q;
        bus.c_address0 = addr2_q;
        bus.c_d0       = sum_q;
    end

    a_state_onehot: assert property (@(posedge ap_clk) disable iff (ap_rst)
        $onehot(state_q));

    a_read_in_range: assert property (@(posedge ap_clk) disable iff (ap_rst)
        bus.a_ce0 |-> (32'(bus.a_address0) < N));

endmodule

// File: tb/tb_matrix_add_pipe.sv
// Directed bench for matrix_add_pipe: 2x2 and 1x1 instances, DATA_W=8.
module tb_matrix_add_pipe;

    logic ap_clk;
    logic ap_rst;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    matrix_add_pipe_if #(.DATA_W(8), .ADDR_W(2)) bus2 ();
    matrix_add_pipe_if #(.DATA_W(8), .ADDR_W(1)) bus1 ();

    matrix_add_pipe #(.ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(2)) u_dut2 (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus2)
    );

    matrix_add_pipe #(.ROWS(1), .COLS(1), .DATA_W(8), .ADDR_W(1)) u_dut1 (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mem_a2 [4];
    logic [7:0] mem_b2 [4];
    logic [7:0] mem_a1;
    logic [7:0] mem_b1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    ev_t  wr2 [$];
    ev_t  rd2 [$];
    ev_t  wr1 [$];
    int   done2 [$];
    int   rdy2 [$];
    int   done1 [$];
    logic idle2 [int];

    typedef struct packed {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [3:0][7:0] c;
    } vec_t;

    vec_t vecs [4];

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Memory models with 1-cycle read latency.
    always @(posedge ap_clk) begin
        if (bus2.a_ce0) bus2.a_q0 <= mem_a2[bus2.a_address0];
        if (bus2.b_ce0) bus2.b_q0 <= mem_b2[bus2.b_address0];
        if (bus1.a_ce0) bus1.a_q0 <= mem_a1;
        if (bus1.b_ce0) bus1.b_q0 <= mem_b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge ap_clk) begin
        ev_t e;
        idle2[cyc] = bus2.ap_idle;
        if (bus2.c_we0 === 1'b1) begin
            e.cyc = cyc; e.addr = int'(bus2.c_address0); e.data = int'(bus2.c_d0);
            wr2.push_back(e);
        end
        if (bus2.a_ce0 === 1'b1) begin
            e.cyc = cyc; e.addr = int'(bus2.a_address0); e.data = 0;
            rd2.push_back(e);
            check("rd_ab_same_addr", 32'(bus2.b_address0), 32'(bus2.a_address0));
        end
        if (bus2.ap_done === 1'b1) done2.push_back(cyc);
        if (bus2.ap_ready === 1'b1) rdy2.push_back(cyc);
        if (bus1.c_we0 === 1'b1) begin
            e.cyc = cyc; e.addr = int'(bus1.c_address0); e.data = int'(bus1.c_d0);
            wr1.push_back(e);
        end
        if (bus1.ap_done === 1'b1) done1.push_back(cyc);
    end

    task automatic tick_to(input int target);
        while (cyc < target) @(negedge ap_clk);
    endtask

    task automatic clear2();
        wr2.delete(); rd2.delete(); done2.delete(); rdy2.delete();
    endtask

    task automatic load2(input int v);
        for (int i = 0; i < 4; i++) begin
            mem_a2[i] = vecs[v].a[i];
            mem_b2[i] = vecs[v].b[i];
        end
    endtask

    // Raises start for exactly the accepting cycle; s is that cycle's number.
    task automatic start2(output int s);
        @(negedge ap_clk);
        bus2.ap_start = 1'b1;
        s = cyc;
        @(negedge ap_clk);
        bus2.ap_start = 1'b0;
    endtask

    task automatic check_wr2(input int i, input int ecyc, input int eaddr, input int edata);
        if (wr2.size() <= i) begin
            check("wr2_present", wr2.size(), i + 1);
        end else begin
            check("wr2_cycle", wr2[i].cyc, ecyc);
            check("wr2_addr", wr2[i].addr, eaddr);
            check("wr2_data", wr2[i].data, edata);
        end
    endtask

    task automatic run_vec(input int v);
        int s;
        load2(v);
        clear2();
        start2(s);
        tick_to(s + 10);
        check("wr2_total", wr2.size(), 4);
        for (int i = 0; i < 4; i++) check_wr2(i, s + 3 + i, i, int'(vecs[v].c[i]));
        check("rd2_total", rd2.size(), 4);
        if (rd2.size() > 0) check("rd2_first_cycle", rd2[0].cyc, s + 1);
        if (rd2.size() > 3) check("rd2_last_addr", rd2[3].addr, 3);
        check("done2_count", done2.size(), 1);
        if (done2.size() > 0) check("done2_cycle", done2[0], s + 7);
        check("ready2_count", rdy2.size(), 1);
        if (rdy2.size() > 0) check("ready2_cycle", rdy2[0], s + 7);
        check("idle_low_first", 32'(idle2[s + 1]), 0);
        check("idle_low_done", 32'(idle2[s + 7]), 0);
        check("idle_high_after", 32'(idle2[s + 8]), 1);
    endtask

    initial begin
        int s;

        vecs[0].a = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].b = {8'd40, 8'd30, 8'd20, 8'd10};
        vecs[0].c = {8'd44, 8'd33, 8'd22, 8'd11};
        vecs[1].a = {8'h7F, 8'h00, 8'h80, 8'hFF};
        vecs[1].b = {8'h01, 8'h00, 8'h80, 8'h01};
        vecs[1].c = {8'h80, 8'h00, 8'h00, 8'h00};
        vecs[2].a = {8'd17, 8'd255, 8'd100, 8'd200};
        vecs[2].b = {8'd3, 8'd255, 8'd156, 8'd55};
        vecs[2].c = {8'd20, 8'd254, 8'd0, 8'd255};
        vecs[3].a = {8'd128, 8'd64, 8'd32, 8'd16};
        vecs[3].b = {8'd8, 8'd4, 8'd2, 8'd1};
        vecs[3].c = {8'd136, 8'd68, 8'd34, 8'd17};

        bus2.ap_start = 1'b0;
        bus1.ap_start = 1'b0;
        mem_a1 = 8'd0;
        mem_b1 = 8'd0;
        ap_rst = 1'b0;
        #1 ap_rst = 1'b1;
        #1;
        check("rst_idle", 32'(bus2.ap_idle), 1);
        check("rst_done", 32'(bus2.ap_done), 0);
        check("rst_ready", 32'(bus2.ap_ready), 0);
        check("rst_a_ce", 32'(bus2.a_ce0), 0);
        check("rst_c_we", 32'(bus2.c_we0), 0);
        check("rst_c_ce", 32'(bus2.c_ce0), 0);
        check("rst_c_d", 32'(bus2.c_d0), 0);
        check("rst_c_addr", 32'(bus2.c_address0), 0);
        check("rst_a_addr", 32'(bus2.a_address0), 0);
        check("rst_idle_1x1", 32'(bus1.ap_idle), 1);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        for (int v = 0; v < 4; v++) run_vec(v);

        // 1x1 matrix: single read, write at S+3, done at S+4.
        mem_a1 = 8'd5;
        mem_b1 = 8'd7;
        wr1.delete();
        done1.delete();
        @(negedge ap_clk);
        bus1.ap_start = 1'b1;
        s = cyc;
        @(negedge ap_clk);
        bus1.ap_start = 1'b0;
        tick_to(s + 8);
        check("n1_wr_total", wr1.size(), 1);
        if (wr1.size() > 0) begin
            check("n1_wr_cycle", wr1[0].cyc, s + 3);
            check("n1_wr_addr", wr1[0].addr, 0);
            check("n1_wr_data", wr1[0].data, 12);
        end
        check("n1_done_count", done1.size(), 1);
        if (done1.size() > 0) check("n1_done_cycle", done1[0], s + 4);

        // Start held high: back-to-back runs, second accepted in S+8.
        load2(0);
        clear2();
        @(negedge ap_clk);
        bus2.ap_start = 1'b1;
        s = cyc;
        tick_to(s + 9);
        bus2.ap_start = 1'b0;
        tick_to(s + 20);
        check("held_wr_total", wr2.size(), 8);
        check_wr2(3, s + 6, 3, 44);
        check_wr2(4, s + 11, 0, 11);
        check_wr2(7, s + 14, 3, 44);
        check("held_done_count", done2.size(), 2);
        if (done2.size() > 1) check("held_done2_cycle", done2[1], s + 15);

        // Start toggled during RUN is ignored.
        load2(1);
        clear2();
        start2(s);
        @(negedge ap_clk) bus2.ap_start = 1'b1;
        @(negedge ap_clk) bus2.ap_start = 1'b0;
        @(negedge ap_clk) bus2.ap_start = 1'b1;
        @(negedge ap_clk) bus2.ap_start = 1'b0;
        tick_to(s + 14);
        check("tog_wr_total", wr2.size(), 4);
        check_wr2(0, s + 3, 0, 0);
        check_wr2(3, s + 6, 3, 8'h80);
        check("tog_done_count", done2.size(), 1);

        // Reset in cycle S+5 aborts the run.
        load2(0);
        clear2();
        start2(s);
        tick_to(s + 4);
        @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        #1;
        check("abort_c_we", 32'(bus2.c_we0), 0);
        check("abort_c_ce", 32'(bus2.c_ce0), 0);
        check("abort_a_ce", 32'(bus2.a_ce0), 0);
        check("abort_idle", 32'(bus2.ap_idle), 1);
        check("abort_done", 32'(bus2.ap_done), 0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        tick_to(s + 14);
        check("abort_wr_total", wr2.size(), 2);
        check("abort_done_count", done2.size(), 0);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_add_pipe.md
MATRIX_ADD_PIPE -- requirements
Module: matrix_add_pipe

Interface
REQ-001 The block SHALL expose these parameters: ROWS, 3, matrix row count (>=1).
REQ-002 COLS, 3, matrix column count (>=1); N = ROWS*COLS.
REQ-003 DATA_W, 32, element width, unsigned.
REQ-004 ADDR_W, clog2(max(N,2)), flat element address width.
REQ-005 One clock; reset is asynchronous and active-high: ap_clk in 1 rising-edge clock; ap_rst in 1 asynchronous active-high reset.
REQ-006 ap_start in 1, request to start one matrix add, held high until ap_ready.
REQ-007 ap_done out 1, one-cycle pulse, all N results written.
REQ-008 ap_ready out 1, one-cycle pulse, new ap_start may be accepted.
REQ-009 ap_idle out 1, high when no operation is in progress.
REQ-010 a_address0 out ADDR_W, A read address; a_ce0 out 1, A read enable; a_q0 in DATA_W, A read data.
REQ-011 b_address0 out ADDR_W, B read address; b_ce0 out 1, B read enable; b_q0 in DATA_W, B read data.
REQ-012 c_address0 out ADDR_W, C write address; c_ce0 out 1, C enable; c_we0 out 1, C write strobe; c_d0 out DATA_W, C write data.

Function
REQ-013 Memories SHALL be treated as 1-cycle read latency: q0 valid in the cycle after ce0 high with an address.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; ap_ST_fsm encoding is one-hot.
REQ-015 IDLE: ap_idle=1; if ap_start=1 at a rising edge, next state RUN with issue counter k=0; else stay.
REQ-016 RUN: 3-stage pipeline, II=1, no stalls; enable bits iter0, iter1, iter2.
REQ-017 Stage iter0 SHALL assert a_ce0=b_ce0=1 with both addresses = k for k = 0..N-1, one index per cycle, row-major (addr = r*COLS+c).
REQ-018 Stage iter1 SHALL register sum = (a_q0 + b_q0) mod 2^DATA_W and its address; carry-out discarded.
REQ-019 Stage iter2 SHALL assert c_ce0=c_we0=1 with c_address0/c_d0 from the iter1 register.
REQ-020 With start accepted at edge S (cycle S), reads SHALL occur in cycles S+1..S+N, writes in cycles S+3..S+N+2, exactly N writes, each address once, ascending.
REQ-021 After the iter2 enable of index N-1 drains, state SHALL go to DONE; DONE lasts one cycle (S+N+3) with ap_done=ap_ready=1, then IDLE.
REQ-022 ap_idle SHALL be 0 in cycles S+1..S+N+3.
REQ-023 ap_start in RUN or DONE SHALL be ignored; if ap_start=1 in the first IDLE cycle after DONE, a new operation starts, with no cycle overlap of writes.
REQ-024 Outside iter0/iter2 activity, ce/we strobes SHALL be 0; address/data outputs are don't-care but SHALL not be X after reset.
REQ-025 N=1: read in S+1, write in S+3, ap_done in S+4.
REQ-026 Counter k SHALL saturate at N (issue stop); no address >= N is ever driven with ce high.

Reset
REQ-027 ap_rst=1 SHALL asynchronously force: state IDLE, ap_idle=1, ap_done=ap_ready=0, all ce/we=0, enable bits 0, counter 0, address/data registers 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation immediately: no further C writes, no ap_done pulse for it; ap_start after release begins fresh from index 0.

Verification
REQ-029 ROWS=COLS=2, DATA_W=8, A={1,2,3,4}, B={10,20,30,40}, start at edge S -> C={11,22,33,44} written at S+3..S+6, ap_done/ap_ready pulse at S+7, ap_idle high at S+8.
REQ-030 ROWS=COLS=1, A={5}, B={7} -> single write addr 0 data 12 at S+3, ap_done at S+4.
REQ-031 DATA_W=8, A={0xFF,0x80}, B={0x01,0x80} (ROWS=1,COLS=2) -> C={0x00,0x00}, no extra output or flag.
REQ-032 ap_start held high continuously, ROWS=COLS=2 -> two runs, second start accepted in cycle S+8, writes at S+11..S+14, exactly 8 writes total, two ap_done pulses.
REQ-033 ROWS=COLS=3, ap_rst pulsed in cycle S+5 -> no c_we0 after reset assertion, no ap_done, outputs at reset values, ap_idle=1; subsequent start completes all 9 writes correctly.
REQ-034 ap_start toggled 1->0->1 during RUN -> ignored; exactly N writes and one ap_done per accepted start.
